// File: rtl/udp_i2c_tmp_poll.sv
// Multi-channel I2C temperature poller. It scans P_NCH sensors through an external udp_i2c
// master and formats each 16-bit reading (LSB = 1/128 degC) as the ASCII string "+ddd.d".
//
// state | meaning
// IDLE  | wait for a start pulse or period-timer expiry
// REQ   | one-cycle read request for channel r_ch
// RD0   | wait for the high byte
// RD1   | wait for the low byte
// CONV  | format the reading and update the channel flags
// FLUSH | after a NACK or timeout, wait for the core to go idle
// NEXT  | advance to the next channel, or finish the scan
// DONE  | one-cycle end pulse and period-timer reload
module udp_i2c_tmp_poll #(
   parameter int unsigned P_NCH       = 2,
   parameter logic [7:0]  P_BASE_ADDR = 8'h96,
   parameter logic [31:0] P_PERIOD    = 32'd0,
   parameter logic [23:0] P_TIMEOUT   = 24'd100000
) (
   input  logic                i2c_clk,
   input  logic                rst,
   input  logic                i_i2c_start,
   output logic                o_i2c_end,
   output logic                o_busy,
   output logic [7:0]          o_slave_addr,
   output logic [7:0]          o_num_bytes,
   output logic                o_mst_read,
   input  logic                i_mst_data_out_valid,
   input  logic [7:0]          i_mst_data_out,
   input  logic                i_i2c_busy,
   input  logic                i_i2c_rxak,
   output logic [48*P_NCH-1:0] o_data_ascii,
   output logic [P_NCH-1:0]    o_valid,
   output logic [P_NCH-1:0]    o_err
);
   localparam int unsigned       LP_CHW       = (P_NCH > 1) ? $clog2(P_NCH) : 1;
   localparam logic [47:0]       LP_ASCII_RST = 48'h2B30_3030_2E30;
   localparam logic [LP_CHW-1:0] LP_CH_LAST   = LP_CHW'(P_NCH - 1);

   typedef enum logic [2:0] {
      S_IDLE, S_REQ, S_RD0, S_RD1, S_CONV, S_FLUSH, S_NEXT, S_DONE
   } state_t;

   state_t              r_state, w_state_nxt;
   logic [LP_CHW-1:0]   r_ch;
   logic [15:0]         r_raw;
   logic [23:0]         r_tmo;
   logic [31:0]         r_per;
   logic [48*P_NCH-1:0] r_ascii;
   logic [P_NCH-1:0]    r_valid;
   logic [P_NCH-1:0]    r_err;

   logic        w_per_exp;
   logic        w_rd_err;
   logic [15:0] w_mag;
   logic [8:0]  w_int;
   logic [3:0]  w_h, w_t, w_o, w_d;
   logic [47:0] w_str;

   assign w_per_exp = (P_PERIOD != 32'd0) && (r_per == 32'd0);
   assign w_rd_err  = i_i2c_rxak || (r_tmo == P_TIMEOUT - 24'd1);

   assign o_slave_addr = P_BASE_ADDR + (8'(r_ch) << 1);
   assign o_num_bytes  = 8'd2;
   assign o_data_ascii = r_ascii;
   assign o_valid      = r_valid;
   assign o_err        = r_err;

   always_comb begin
      w_state_nxt = r_state;
      o_mst_read  = 1'b0;
      o_i2c_end   = 1'b0;
      o_busy      = (r_state != S_IDLE);
      case (r_state)
         S_IDLE:  if (i_i2c_start || w_per_exp) w_state_nxt = S_REQ;
         S_REQ: begin
            o_mst_read  = 1'b1;
            w_state_nxt = S_RD0;
         end
         S_RD0: begin
            if (w_rd_err)                  w_state_nxt = S_FLUSH;
            else if (i_mst_data_out_valid) w_state_nxt = S_RD1;
         end
         S_RD1: begin
            if (w_rd_err)                  w_state_nxt = S_FLUSH;
            else if (i_mst_data_out_valid) w_state_nxt = S_CONV;
         end
         S_CONV:  w_state_nxt = S_NEXT;
         S_FLUSH: if (!i_i2c_busy) w_state_nxt = S_NEXT;
         S_NEXT:  w_state_nxt = (r_ch == LP_CH_LAST) ? S_DONE : S_REQ;
         S_DONE: begin
            o_i2c_end   = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Magnitude is 16-bit unsigned so 0x8000 yields 32768 (256.0 degC).
   always_comb begin
      w_mag = r_raw[15] ? (~r_raw + 16'd1) : r_raw;
      w_int = w_mag[15:7];
      w_h   = 4'(w_int / 9'd100);
      w_t   = 4'((w_int / 9'd10) % 9'd10);
      w_o   = 4'(w_int % 9'd10);
      w_d   = 4'((11'(w_mag[6:0]) * 11'd10) >> 7);
      w_str = {(r_raw[15] ? 8'h2D : 8'h2B), {4'h3, w_h}, {4'h3, w_t}, {4'h3, w_o},
               8'h2E, {4'h3, w_d}};
   end

   always_ff @(posedge i2c_clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_ch    <= '0;
         r_raw   <= '0;
         r_tmo   <= '0;
         r_per   <= P_PERIOD - 32'd1;
         r_ascii <= {P_NCH{LP_ASCII_RST}};
         r_valid <= '0;
         r_err   <= '0;
      end else begin
         r_state <= w_state_nxt;
         case (r_state)
            S_IDLE: begin
               r_ch <= '0;
               if (r_per != 32'd0) r_per <= r_per - 32'd1;
            end
            S_REQ: r_tmo <= '0;
            S_RD0: begin
               if (w_rd_err) begin
                  r_err[r_ch] <= 1'b1;
               end else if (i_mst_data_out_valid) begin
                  r_raw[15:8] <= i_mst_data_out;
                  r_tmo       <= '0;
               end else begin
                  r_tmo <= r_tmo + 24'd1;
               end
            end
            S_RD1: begin
               if (w_rd_err)                  r_err[r_ch] <= 1'b1;
               else if (i_mst_data_out_valid) r_raw[7:0]  <= i_mst_data_out;
               else                           r_tmo       <= r_tmo + 24'd1;
            end
            S_CONV: begin
               r_ascii[48*int'(r_ch) +: 48] <= w_str;
               r_valid[r_ch]                <= 1'b1;
               r_err[r_ch]                  <= 1'b0;
            end
            S_NEXT: if (r_ch != LP_CH_LAST) r_ch <= r_ch + LP_CHW'(1);
            S_DONE: r_per <= P_PERIOD - 32'd1;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_udp_i2c_tmp_poll.sv
// Bench for udp_i2c_tmp_poll: a two-channel instance driven by scripted core tasks and a
// single-channel periodic instance served by a free-running core responder.
module tb_udp_i2c_tmp_poll;
   localparam logic [47:0] RST_STR = 48'h2B30_3030_2E30;
   localparam int PER    = 50;
   localparam int P_D0   = 2;
   localparam int P_SCAN = 1 * (5 + P_D0) + 1;
   localparam int M_GOOD = 0, M_NACK = 1, M_TMO = 2, M_BOTH = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst_a   = 1'b1;
   logic        start_a = 1'b0;
   logic        vld_a   = 1'b0;
   logic        cbusy_a = 1'b0;
   logic        rxak_a  = 1'b0;
   logic [7:0]  dat_a   = 8'h00;
   logic        end_a, busy_a, rd_a;
   logic [7:0]  addr_a, nb_a;
   logic [95:0] ascii_a;
   logic [1:0]  valid_a, err_a;

   logic        rst_p   = 1'b1;
   logic        start_p = 1'b0;
   logic        vld_p   = 1'b0;
   logic        cbusy_p = 1'b0;
   logic        rxak_p  = 1'b0;
   logic [7:0]  dat_p   = 8'h00;
   logic        end_p, busy_p, rd_p;
   logic [7:0]  addr_p, nb_p;
   logic [47:0] ascii_p;
   logic [0:0]  valid_p, err_p;

   udp_i2c_tmp_poll #(.P_NCH(2), .P_BASE_ADDR(8'h96), .P_PERIOD(32'd0), .P_TIMEOUT(24'd16)) u_a (
      .i2c_clk(clk), .rst(rst_a), .i_i2c_start(start_a), .o_i2c_end(end_a), .o_busy(busy_a),
      .o_slave_addr(addr_a), .o_num_bytes(nb_a), .o_mst_read(rd_a),
      .i_mst_data_out_valid(vld_a), .i_mst_data_out(dat_a), .i_i2c_busy(cbusy_a),
      .i_i2c_rxak(rxak_a), .o_data_ascii(ascii_a), .o_valid(valid_a), .o_err(err_a));

   udp_i2c_tmp_poll #(.P_NCH(1), .P_BASE_ADDR(8'h96), .P_PERIOD(PER), .P_TIMEOUT(24'd100000)) u_p (
      .i2c_clk(clk), .rst(rst_p), .i_i2c_start(start_p), .o_i2c_end(end_p), .o_busy(busy_p),
      .o_slave_addr(addr_p), .o_num_bytes(nb_p), .o_mst_read(rd_p),
      .i_mst_data_out_valid(vld_p), .i_mst_data_out(dat_p), .i_i2c_busy(cbusy_p),
      .i_i2c_rxak(rxak_p), .o_data_ascii(ascii_p), .o_valid(valid_p), .o_err(err_p));

   int          n_chk = 0;
   int          n_pass = 0;
   int          end_cnt_a = 0;
   int          cyc = 0;
   int          q_end_p[$];
   logic [15:0] raw_p, last_raw_p;
   logic [47:0] exp_ascii[2];
   logic [1:0]  exp_valid, exp_err;
   bit          poke_a = 1'b0;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (end_a === 1'b1) end_cnt_a <= end_cnt_a + 1;
      if (end_p === 1'b1) q_end_p.push_back(cyc);
   end

   // Reference formatting: value in tenths of a degree, truncated toward zero.
   function automatic logic [47:0] ascii_ref(input logic [15:0] raw);
      int v, mag, tt, ip, fd;
      v   = int'($signed(raw));
      mag = (v < 0) ? -v : v;
      tt  = (mag * 10) / 128;
      ip  = tt / 10;
      fd  = tt % 10;
      return {(v < 0) ? 8'h2D : 8'h2B, 8'(48 + ip / 100), 8'(48 + (ip / 10) % 10),
              8'(48 + ip % 10), 8'h2E, 8'(48 + fd)};
   endfunction

   // Core responder for the periodic instance: two idle cycles, then both bytes.
   always begin
      @(negedge clk);
      if (rd_p === 1'b1) begin
         cbusy_p = 1'b1;
         raw_p   = 16'($urandom);
         repeat (3) @(negedge clk);
         vld_p = 1'b1;
         dat_p = raw_p[15:8];
         @(negedge clk);
         dat_p = raw_p[7:0];
         @(negedge clk);
         vld_p      = 1'b0;
         cbusy_p    = 1'b0;
         last_raw_p = raw_p;
      end
   end

   task automatic chan_a(input int ch, input int mode, input logic [15:0] raw, input int d0);
      bit         seen;
      int         nrd;
      logic [7:0] exp_addr;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         if (rd_a === 1'b1) begin
            seen = 1'b1;
            break;
         end
         @(negedge clk);
      end
      n_chk++;
      if (!seen) begin
         $display("FAIL req_seen ch%0d: o_mst_read not seen within 20 cycles", ch);
         return;
      end
      n_pass++;
      exp_addr = 8'(150 + 2 * ch);
      n_chk++;
      if (addr_a !== exp_addr) $display("FAIL req_addr ch%0d: got %h want %h", ch, addr_a, exp_addr);
      else n_pass++;
      n_chk++;
      if (busy_a !== 1'b1) $display("FAIL busy_in_scan ch%0d: got %b want 1", ch, busy_a);
      else n_pass++;
      cbusy_a = 1'b1;
      @(negedge clk);
      n_chk++;
      if (rd_a !== 1'b0) $display("FAIL read_pulse_width ch%0d: got %b want 0", ch, rd_a);
      else n_pass++;

      if (mode == M_GOOD) begin
         for (int k = 0; k < d0; k++) begin
            if (poke_a && k == 0) start_a = 1'b1;
            @(negedge clk);
            start_a = 1'b0;
         end
         vld_a = 1'b1;
         dat_a = raw[15:8];
         @(negedge clk);
         dat_a = raw[7:0];
         @(negedge clk);
         vld_a   = 1'b0;
         cbusy_a = 1'b0;
         @(negedge clk);
         exp_ascii[ch] = ascii_ref(raw);
         exp_valid[ch] = 1'b1;
         exp_err[ch]   = 1'b0;
      end else if (mode == M_TMO) begin
         for (int j = 1; j <= 15; j++) @(negedge clk);
         n_chk++;
         if (err_a[ch] !== exp_err[ch])
            $display("FAIL tmo_early ch%0d: got %b want %b", ch, err_a[ch], exp_err[ch]);
         else n_pass++;
         @(negedge clk);
         exp_err[ch] = 1'b1;
         n_chk++;
         if (err_a[ch] !== 1'b1) $display("FAIL tmo_at16 ch%0d: got %b want 1", ch, err_a[ch]);
         else n_pass++;
         nrd = 0;
         for (int k = 0; k < 5; k++) begin
            vld_a = (k == 2);
            dat_a = 8'hA5;
            @(negedge clk);
            if (rd_a === 1'b1) nrd++;
         end
         vld_a   = 1'b0;
         cbusy_a = 1'b0;
         @(negedge clk);
         n_chk++;
         if (nrd != 0) $display("FAIL flush_hold ch%0d: got %0d reads want 0", ch, nrd);
         else n_pass++;
      end else begin
         repeat (d0) @(negedge clk);
         rxak_a = 1'b1;
         if (mode == M_BOTH) begin
            vld_a = 1'b1;
            dat_a = raw[15:8];
         end
         @(negedge clk);
         rxak_a = 1'b0;
         vld_a  = 1'b1;
         dat_a  = 8'h5A;
         @(negedge clk);
         vld_a   = 1'b0;
         cbusy_a = 1'b0;
         @(negedge clk);
         exp_err[ch] = 1'b1;
      end

      n_chk++;
      if (ascii_a[48*ch +: 48] !== exp_ascii[ch])
         $display("FAIL ascii ch%0d: got %h want %h", ch, ascii_a[48*ch +: 48], exp_ascii[ch]);
      else n_pass++;
      n_chk++;
      if (valid_a[ch] !== exp_valid[ch])
         $display("FAIL valid ch%0d: got %b want %b", ch, valid_a[ch], exp_valid[ch]);
      else n_pass++;
      n_chk++;
      if (err_a[ch] !== exp_err[ch])
         $display("FAIL err ch%0d: got %b want %b", ch, err_a[ch], exp_err[ch]);
      else n_pass++;
   endtask

   task automatic scan_a(input int m0, input logic [15:0] r0, input int m1, input logic [15:0] r1,
                         input int d0);
      int e0;
      e0      = end_cnt_a;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      chan_a(0, m0, r0, d0);
      chan_a(1, m1, r1, d0);
      @(negedge clk);
      n_chk++;
      if (end_a !== 1'b1) $display("FAIL end_pulse: got %b want 1", end_a);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if (end_cnt_a != e0 + 1) $display("FAIL end_count: got %0d want %0d", end_cnt_a - e0, 1);
      else n_pass++;
      n_chk++;
      if (busy_a !== 1'b0) $display("FAIL busy_after: got %b want 0", busy_a);
      else n_pass++;
      n_chk++;
      if (ascii_a !== {exp_ascii[1], exp_ascii[0]} || valid_a !== exp_valid || err_a !== exp_err)
         $display("FAIL scan_vectors: got %h/%b/%b want %h/%b/%b", ascii_a, valid_a, err_a,
                  {exp_ascii[1], exp_ascii[0]}, exp_valid, exp_err);
      else n_pass++;
   endtask

   task automatic check_reset_a(input string tag);
      n_chk++;
      if (ascii_a !== {RST_STR, RST_STR} || valid_a !== 2'b00 || err_a !== 2'b00)
         $display("FAIL %s_data: got %h/%b/%b want %h/00/00", tag, ascii_a, valid_a, err_a,
                  {RST_STR, RST_STR});
      else n_pass++;
      n_chk++;
      if (end_a !== 1'b0 || busy_a !== 1'b0 || rd_a !== 1'b0)
         $display("FAIL %s_ctrl: got end=%b busy=%b rd=%b want 0/0/0", tag, end_a, busy_a, rd_a);
      else n_pass++;
      n_chk++;
      if (addr_a !== 8'h96 || nb_a !== 8'd2)
         $display("FAIL %s_addr: got %h/%h want 96/02", tag, addr_a, nb_a);
      else n_pass++;
   endtask

   task automatic test_reset();
      exp_ascii[0] = RST_STR;
      exp_ascii[1] = RST_STR;
      exp_valid    = 2'b00;
      exp_err      = 2'b00;
      @(negedge clk);
      @(negedge clk);
      check_reset_a("reset");
      n_chk++;
      if (ascii_p !== RST_STR || busy_p !== 1'b0)
         $display("FAIL reset_p: got %h/%b want %h/0", ascii_p, busy_p, RST_STR);
      else n_pass++;
      rst_a = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_nack();
      scan_a(M_NACK, 16'h0000, M_GOOD, 16'h1900, 1);
      n_chk++;
      if (valid_a !== 2'b10 || err_a !== 2'b01 || ascii_a[95:48] !== 48'h2B3035302E30)
         $display("FAIL nack_plan: got %b/%b/%h want 10/01/2b3035302e30",
                  valid_a, err_a, ascii_a[95:48]);
      else n_pass++;
   endtask

   task automatic test_basic();
      scan_a(M_GOOD, 16'h0C80, M_GOOD, 16'h1900, 0);
      n_chk++;
      if (ascii_a[47:0] !== 48'h2B3032352E30)
         $display("FAIL basic_ascii: got %h want 2b3032352e30", ascii_a[47:0]);
      else n_pass++;
   endtask

   task automatic test_values();
      logic [15:0] vals[6] = '{16'hF380, 16'h0CC0, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h0001};
      logic [15:0] r0;
      for (int i = 0; i < 10; i++) begin
         r0 = (i < 6) ? vals[i] : 16'($urandom);
         scan_a(M_GOOD, r0, M_GOOD, 16'($urandom), int'($urandom_range(0, 3)));
      end
   endtask

   task automatic test_timeout();
      scan_a(M_TMO, 16'h0000, M_GOOD, 16'($urandom), 1);
   endtask

   task automatic test_err_wins();
      scan_a(M_BOTH, 16'h1234, M_GOOD, 16'($urandom), 2);
   endtask

   task automatic test_start_ignored();
      int e0, nrd;
      poke_a = 1'b1;
      scan_a(M_GOOD, 16'($urandom), M_GOOD, 16'($urandom), 2);
      poke_a = 1'b0;
      e0  = end_cnt_a;
      nrd = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (rd_a === 1'b1) nrd++;
      end
      n_chk++;
      if (nrd != 0 || end_cnt_a != e0)
         $display("FAIL start_ignored: got %0d reads %0d ends want 0/0", nrd, end_cnt_a - e0);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      int e0;
      start_a = 1'b1;
      @(negedge clk);
      start_a = 1'b0;
      for (int i = 0; i < 20 && rd_a !== 1'b1; i++) @(negedge clk);
      n_chk++;
      if (rd_a !== 1'b1) $display("FAIL rmid_req: got %b want 1", rd_a);
      else n_pass++;
      cbusy_a = 1'b1;
      @(negedge clk);
      vld_a = 1'b1;
      dat_a = 8'h12;
      @(negedge clk);
      vld_a = 1'b0;
      e0    = end_cnt_a;
      #1 rst_a = 1'b1;
      #1;
      check_reset_a("rmid");
      exp_ascii[0] = RST_STR;
      exp_ascii[1] = RST_STR;
      exp_valid    = 2'b00;
      exp_err      = 2'b00;
      cbusy_a      = 1'b0;
      repeat (3) @(negedge clk);
      rst_a = 1'b0;
      repeat (3) @(negedge clk);
      n_chk++;
      if (end_cnt_a != e0) $display("FAIL rmid_no_end: got %0d ends want 0", end_cnt_a - e0);
      else n_pass++;
      scan_a(M_GOOD, 16'($urandom), M_GOOD, 16'($urandom), 1);
   endtask

   task automatic test_period();
      int k;
      @(negedge clk);
      rst_p = 1'b0;
      k = 0;
      while (q_end_p.size() < 1 && k < 400) begin @(negedge clk); k++; end
      k = 0;
      while (busy_p !== 1'b1 && k < 200) begin @(negedge clk); k++; end
      start_p = 1'b1;
      @(negedge clk);
      start_p = 1'b0;
      k = 0;
      while (q_end_p.size() < 3 && k < 400) begin @(negedge clk); k++; end
      k = 0;
      while (end_p !== 1'b1 && k < 200) begin @(negedge clk); k++; end
      repeat (PER) @(negedge clk);
      start_p = 1'b1;
      @(negedge clk);
      start_p = 1'b0;
      k = 0;
      while (q_end_p.size() < 6 && k < 400) begin @(negedge clk); k++; end
      n_chk++;
      if (q_end_p.size() < 6) begin
         $display("FAIL period_ends: got %0d ends want 6", q_end_p.size());
      end else begin
         n_pass++;
         for (int i = 0; i < 5; i++) begin
            n_chk++;
            if (q_end_p[i+1] - q_end_p[i] != PER + P_SCAN)
               $display("FAIL period_gap%0d: got %0d want %0d", i,
                        q_end_p[i+1] - q_end_p[i], PER + P_SCAN);
            else n_pass++;
         end
      end
      n_chk++;
      if (ascii_p !== ascii_ref(last_raw_p) || valid_p !== 1'b1 || err_p !== 1'b0)
         $display("FAIL period_data: got %h/%b/%b want %h/1/0", ascii_p, valid_p, err_p,
                  ascii_ref(last_raw_p));
      else n_pass++;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_nack();
      test_basic();
      test_values();
      test_timeout();
      test_err_wins();
      test_start_ignored();
      test_reset_mid();
      test_period();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/udp_i2c_tmp_poll.md
Name: udp_i2c_tmp_poll

Overview:
Multi-channel I2C temperature poller that drives an external udp_i2c master core. It reads a 16-bit two's-complement reading from P_NCH sensors at consecutive addresses, either on a start pulse or on a periodic timer, and converts each reading to a 6-character ASCII string "+ddd.d" for UDP packet assembly. It adds per-channel valid/error flags, a NACK/timeout recovery path and sign plus one-decimal-place formatting. It sits between the UDP packet builder and udp_i2c.

Parameters:
P_NCH, 2, number of sensors, 1..4
P_BASE_ADDR, 8'h96, 8-bit address of channel 0; channel n uses P_BASE_ADDR + 2*n
P_PERIOD, 32'd0, cycles from one scan end to the next auto scan; 0 = auto scan disabled
P_TIMEOUT, 24'd100000, maximum cycles to wait for each data byte

Ports:
i2c_clk  in  1  sole clock
rst  in  1  asynchronous reset, active-high
i_i2c_start  in  1  single-cycle pulse that requests one scan of all channels
o_i2c_end  out  1  single-cycle pulse when a scan completes
o_busy  out  1  high from scan accept until o_i2c_end
o_slave_addr  out  8  to core i2c_slave_addr
o_num_bytes  out  8  to core; constant 8'd2
o_mst_read  out  1  to core; single-cycle read request
i_mst_data_out_valid  in  1  from core; byte strobe
i_mst_data_out  in  8  from core; byte value
i_i2c_busy  in  1  from core
i_i2c_rxak  in  1  from core; 1 = NACK received
o_data_ascii  out  48*P_NCH  channel n occupies bits [48n+47:48n], MSB = sign character
o_valid  out  P_NCH  sticky; set on a good read, cleared only by reset
o_err  out  P_NCH  result of the channel's last attempt (1 = NACK or timeout)

Behaviour:
- Reset values:
  - All outputs are 0.
  - o_data_ascii resets to "+000.0" per channel (48'h2B30_3030_2E30).
  - o_slave_addr resets to P_BASE_ADDR.
  - o_num_bytes always reads 8'd2.
- States: IDLE, REQ, RD0, RD1, CONV, FLUSH, NEXT, DONE.
- IDLE:
  - A scan starts on i_i2c_start, or on period-counter expiry when P_PERIOD != 0.
  - Start and expiry in the same cycle produce one scan.
  - Channel index resets to 0. Go to REQ.
  - i_i2c_start while o_busy = 1 is ignored (not queued).
- REQ:
  - o_slave_addr = P_BASE_ADDR + 2*ch.
  - o_mst_read is high for exactly this one cycle.
  - Clear the timeout counter. Go to RD0.
- RD0:
  - On valid, latch raw[15:8], clear the timeout counter, go to RD1.
- RD1:
  - On valid, latch raw[7:0], go to CONV.
- Error path, RD0/RD1:
  - Error condition: i_i2c_rxak = 1, or timeout counter == P_TIMEOUT-1.
  - On error: set err[ch], leave ascii[ch] and valid[ch] unchanged, go to FLUSH.
  - If error and valid arrive in the same cycle, error wins.
- FLUSH:
  - Wait until i_i2c_busy = 0.
  - Bytes that arrive in FLUSH are discarded.
  - Go to NEXT.
- CONV: one cycle.
  - mag = raw[15] ? (~raw + 1) : raw, treated as 16-bit unsigned so that 0x8000 gives 32768.
  - int = mag >> 7 (range 0..256).
  - tenths = (mag[6:0] * 10) >> 7, truncated.
  - Characters: sign '+' (8'h2B) or '-' (8'h2D) taken from raw[15], so raw 0xFFFF gives '-'; then hundreds, tens and ones of int, each + 8'h30; then '.' (8'h2E); then tenths + 8'h30.
  - Register the string into ascii[ch]; set valid[ch]; clear err[ch]. Go to NEXT.
- NEXT:
  - If ch == P_NCH-1, go to DONE.
  - Otherwise ch++ and go to REQ.
- DONE:
  - o_i2c_end pulses for 1 cycle, coincident with the DONE state.
  - Reload the period counter. Go to IDLE.
- Period counter: counts only in IDLE and expires after P_PERIOD cycles.
- Updates are atomic: all 48 bits of a channel's ascii change in the same cycle.
- Reset mid-scan: everything returns immediately to reset values; no o_i2c_end is produced.
- Latency, ideal core: REQ → valid byte 1 (core-dependent) → byte 2 → CONV (1 cycle) → NEXT (1 cycle).

Test Plan:
- P_NCH=1, start pulse, core returns 0x0C, 0x80 → o_mst_read 1 cycle with addr 0x96; ascii "+025.0" (2B3032352E30); valid=1, err=0; one o_i2c_end.
- Sign and fraction, one scan per value:
  - 0xF380 → "-025.0"
  - 0x0CC0 → "+025.5"
  - 0x7FFF → "+255.9"
  - 0x8000 → "-256.0"
  - 0xFFFF → "-000.0"
  - 0x0001 → "+000.0"
- P_NCH=2; channel 0 NACKs (rxak=1 in RD0), channel 1 returns 0x1900 → err=2'b01, valid=2'b10, ascii1 "+050.0", ascii0 unchanged; addresses 0x96 then 0x98; o_i2c_end after channel 1.
- Timeout: P_TIMEOUT=16, no valid after REQ, i_i2c_busy held 5 more cycles → err set 16 cycles after entering RD0; FLUSH holds until busy drops; a late byte during FLUSH is ignored.
- P_PERIOD=50, no start pulses → scans repeat, o_i2c_end spaced by 50 + scan length cycles; a start pulse mid-scan is ignored, so the scan count is unchanged.
- Reset asserted during RD1 → all outputs at reset values asynchronously; no o_i2c_end; the next start performs a full scan.
